// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg : shared binary32 field widths, exponent limits and divider states
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fpu_pkg;
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } fdiv_state_t;
endpackage

`default_nettype wire

// File: rtl/fdiv_mant_step.sv
// ---------------------------------------------------------------------------
// fdiv_mant_step : one restoring-division step, one quotient bit per call
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fdiv_mant_step #(
  parameter int W = 24
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] divisor,
  output logic [W:0]   next_rem,
  output logic         qbit
);
  logic [W+1:0] diff;
  logic [W:0]   sel;

  // The partial remainder is always below the divisor after selection,
  // so the left shift never loses a set bit.
  always_comb begin
    diff     = {1'b0, rem} - {2'b00, divisor};
    qbit     = ~diff[W+1];
    sel      = qbit ? diff[W:0] : rem;
    next_rem = sel << 1;
  end
endmodule

`default_nettype wire

// File: rtl/fdiv_iter.sv
// ---------------------------------------------------------------------------
// fdiv_iter : iterative binary32 divider, restoring mantissa division + RNE
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fdiv_iter
  import fpu_pkg::*;
#(
  parameter int QBITS = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf
);
  localparam int MW = MAN_W + 1;

  fdiv_state_t       state, state_next;
  logic [4:0]        cnt;
  logic [MW:0]       rem, step_rem;
  logic [MW-1:0]     dvs;
  logic [QBITS-1:0]  q;
  logic              step_q, sign, special, spec_zero, accept;
  logic [EXP_W-1:0]  e1, e2;
  logic              e1z, e2z, e1m, e2m;
  logic signed [9:0] exp_acc, exp_n, exp_f;
  logic [MAN_W-1:0]  mant_n;
  logic              guard, sticky, inc;
  logic [MW-1:0]     mant_r;
  logic [31:0]       res;
  logic              res_ovf;

  assign e1  = x1[MAN_W +: EXP_W];
  assign e2  = x2[MAN_W +: EXP_W];
  assign e1z = (e1 == '0);
  assign e2z = (e2 == '0);
  assign e1m = (e1 == '1);
  assign e2m = (e2 == '1);

  // Reset gates in_ready combinationally so it reads 0 for the whole reset.
  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  fdiv_mant_step #(.W(MW)) u_step (
    .rem      (rem),
    .divisor  (dvs),
    .next_rem (step_rem),
    .qbit     (step_q)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = DIV;
      DIV:     if (cnt == 5'(QBITS - 1)) state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Normalize the 26-bit quotient, then round to nearest-even.
  always_comb begin
    exp_n  = exp_acc;
    mant_n = q[QBITS-2 -: MAN_W];
    guard  = q[QBITS-2-MAN_W];
    sticky = q[0] | (rem != '0);
    if (!q[QBITS-1]) begin
      exp_n  = exp_acc - 10'sd1;
      mant_n = q[QBITS-3 -: MAN_W];
      guard  = q[0];
      sticky = (rem != '0);
    end
    inc     = guard & (sticky | mant_n[0]);
    mant_r  = {1'b0, mant_n} + {{MAN_W{1'b0}}, inc};
    exp_f   = exp_n + $signed({9'd0, mant_r[MW-1]});
    res_ovf = 1'b0;
    res     = {sign, exp_f[EXP_W-1:0], mant_r[MAN_W-1:0]};
    if (special) begin
      res = {sign, {EXP_W{~spec_zero}}, {MAN_W{1'b0}}};
    end else if (exp_f >= $signed(10'(EXP_MAX))) begin
      res     = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_ovf = 1'b1;
    end else if (exp_f <= 10'sd0) begin
      res = {sign, 31'd0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rem       <= '0;
      dvs       <= '0;
      q         <= '0;
      sign      <= 1'b0;
      exp_acc   <= '0;
      special   <= 1'b0;
      spec_zero <= 1'b0;
      y         <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        cnt       <= '0;
        rem       <= {2'b01, x1[MAN_W-1:0]};
        dvs       <= {1'b1, x2[MAN_W-1:0]};
        q         <= '0;
        sign      <= x1[31] ^ x2[31];
        exp_acc   <= $signed({2'b00, e1} - {2'b00, e2} + 10'(BIAS));
        special   <= e1z | e2z | e1m | e2m;
        spec_zero <= e1z & ~e2z & ~e2m;
      end
      if (state == DIV) begin
        rem <= step_rem;
        q   <= {q[QBITS-2:0], step_q};
        cnt <= cnt + 5'd1;
      end
      if (state == ROUND) begin
        y   <= res;
        ovf <= res_ovf;
      end
      // out_valid rises one edge after DONE is entered and drops on handshake.
      out_valid <= (state == DONE) && !(out_valid && out_ready);
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_fdiv_iter.sv
// ---------------------------------------------------------------------------
// tb_fdiv_iter : directed and random checks for the iterative binary32 divider
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fdiv_iter;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, ovf;
  logic [31:0] x1, x2, y;
  int          cmp = 0;
  int          err = 0;

  always #5 clk = ~clk;

  fdiv_iter #(.QBITS(26)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ovf(ovf)
  );

  // Reference: exact float->double widening, double division, manual RNE to float.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] da, db, dq;
    real         r;
    int          e;
    logic [23:0] m;
    logic        g, st;
    da = {a[31], {3'b000, a[30:23]} + 11'd896, a[22:0], 29'd0};
    db = {b[31], {3'b000, b[30:23]} + 11'd896, b[22:0], 29'd0};
    r  = $bitstoreal(da) / $bitstoreal(db);
    dq = $realtobits(r);
    e  = int'(dq[62:52]) - 896;
    m  = {1'b0, dq[51:29]};
    g  = dq[28];
    st = |dq[27:0];
    if (g && (st || m[0])) m = m + 24'd1;
    if (m[23]) begin
      e = e + 1;
      m = 24'd0;
    end
    return {dq[63], e[7:0], m[22:0]};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, output bit ok);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    ok = in_ready;
    x1 = a; x2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x1 = 32'hDEADBEEF; x2 = 32'h12345678;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] ry, output logic rovf, output int cyc, output bit ok);
    issue(a, b, ok);
    wait_out(cyc);
    ry = y; rovf = ovf;
    consume();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x1 = '0; x2 = '0;
    repeat (3) @(posedge clk);
    #1;
    cmp++; if (in_ready !== 1'b0) begin err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    cmp++; if (y !== 32'h0) begin err++; $display("FAIL reset_y got=%h exp=00000000", y); end
    cmp++; if (ovf !== 1'b0) begin err++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    @(negedge clk); rst = 1'b0; #1;
    cmp++; if (in_ready !== 1'b1) begin err++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_half();
    logic [31:0] ry; logic ro; int cyc; bit ok;
    issue(32'h3F800000, 32'h40000000, ok);
    wait_out(cyc);
    cmp++; if (!ok || cyc !== 28) begin err++; $display("FAIL half_latency got=%0d exp=28 (issued=%0d)", cyc, ok); end
    ry = y; ro = ovf;
    cmp++; if (ry !== 32'h3F000000) begin err++; $display("FAIL half_y got=%h exp=3f000000", ry); end
    cmp++; if (ro !== 1'b0) begin err++; $display("FAIL half_ovf got=%b exp=0", ro); end
    cmp++; if (in_ready !== 1'b0) begin err++; $display("FAIL half_busy_in_ready got=%b exp=0", in_ready); end
    consume();
    cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL half_drop_valid got=%b exp=0", out_valid); end
    cmp++; if (in_ready !== 1'b1) begin err++; $display("FAIL half_ready_after got=%b exp=1", in_ready); end
    cmp++; if (y !== 32'h3F000000) begin err++; $display("FAIL half_y_hold got=%h exp=3f000000", y); end
  endtask

  task automatic test_round();
    logic [31:0] ry; logic ro; int cyc; bit ok;
    run(32'h3F800000, 32'h40400000, ry, ro, cyc, ok);
    cmp++; if (ry !== 32'h3EAAAAAB || ro !== 1'b0 || cyc !== 28) begin
      err++; $display("FAIL third got=%h/%b/%0d exp=3eaaaaab/0/28", ry, ro, cyc); end
    run(32'h40C00000, 32'h40400000, ry, ro, cyc, ok);
    cmp++; if (ry !== 32'h40000000 || ro !== 1'b0) begin
      err++; $display("FAIL six_by_three got=%h/%b exp=40000000/0", ry, ro); end
    run(32'hBF800000, 32'h40000000, ry, ro, cyc, ok);
    cmp++; if (ry !== 32'hBF000000) begin err++; $display("FAIL neg_half got=%h exp=bf000000", ry); end
  endtask

  task automatic test_special();
    logic [31:0] ry; logic ro; int cyc; bit ok;
    logic [31:0] va [6] = '{32'h7F000000, 32'h3F800000, 32'h00800000, 32'h00000000, 32'h7F800000, 32'h80000000};
    logic [31:0] vb [6] = '{32'h3E800000, 32'h00000000, 32'h40000000, 32'h00000000, 32'h40000000, 32'h40000000};
    logic [31:0] ey [6] = '{32'h7F800000, 32'h7F800000, 32'h00000000, 32'h7F800000, 32'h7F800000, 32'h80000000};
    logic        eo [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      run(va[i], vb[i], ry, ro, cyc, ok);
      cmp++; if (ry !== ey[i] || ro !== eo[i] || cyc !== 28) begin
        err++; $display("FAIL special_%0d got=%h/%b/%0d exp=%h/%b/28", i, ry, ro, cyc, ey[i], eo[i]); end
    end
  endtask

  task automatic test_backpressure();
    int cyc; bit ok;
    issue(32'h3F800000, 32'h40400000, ok);
    wait_out(cyc);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cmp++; if (y !== 32'h3EAAAAAB || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        err++; $display("FAIL stall_%0d got y=%h v=%b r=%b exp y=3eaaaaab v=1 r=0", i, y, out_valid, in_ready); end
    end
    in_valid = 1'b1; x1 = 32'h40000000; x2 = 32'h3F800000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cmp++; if (y !== 32'h3EAAAAAB) begin err++; $display("FAIL stall_ignore_in got=%h exp=3eaaaaab", y); end
    consume();
    cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      err++; $display("FAIL stall_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ry; logic ro; int cyc; bit ok;
    issue(32'h3F800000, 32'h40400000, ok);
    repeat (10) @(posedge clk);
    #1; rst = 1'b1; #1;
    cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      err++; $display("FAIL mid_reset got v=%b r=%b exp v=0 r=0", out_valid, in_ready); end
    @(negedge clk); rst = 1'b0; #1;
    cmp++; if (in_ready !== 1'b1) begin err++; $display("FAIL mid_release got=%b exp=1", in_ready); end
    issue(32'h7F000000, 32'h3E800000, ok);
    wait_out(cyc);
    #1; rst = 1'b1; #1;
    cmp++; if (out_valid !== 1'b0 || y !== 32'h0 || ovf !== 1'b0) begin
      err++; $display("FAIL done_reset got v=%b y=%h o=%b exp v=0 y=0 o=0", out_valid, y, ovf); end
    @(negedge clk); rst = 1'b0; #1;
    run(32'h3F800000, 32'h40000000, ry, ro, cyc, ok);
    cmp++; if (ry !== 32'h3F000000 || cyc !== 28) begin
      err++; $display("FAIL after_reset got=%h/%0d exp=3f000000/28", ry, cyc); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, ry, ey; logic ro; int cyc; bit ok;
    for (int i = 0; i < 20; i++) begin
      a = {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
      ey = ref_div(a, b);
      run(a, b, ry, ro, cyc, ok);
      if (ey[30:23] != 8'h00 && ey[30:23] != 8'hFF) begin
        cmp++; if (ry !== ey || ro !== 1'b0) begin
          err++; $display("FAIL rand_%0d %h/%h got=%h/%b exp=%h/0", i, a, b, ry, ro, ey); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_half();
    test_round();
    test_special();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

`default_nettype wire
